// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered syncs, display enable,
// pixel coordinates and line/frame strobes. Optional macro VGA_TIMING_PIX_CE_EN adds a pix_ce input.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int XW         = 10,
  parameter int YW         = 10
) (
  input  logic          clk_in,
  input  logic          reset,
`ifdef VGA_TIMING_PIX_CE_EN
  input  logic          pix_ce,
`endif
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_ACT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE  = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_LST = YW'(V_TOTAL - 1);

  logic          ce;
  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic          h_in, v_in;

`ifdef VGA_TIMING_PIX_CE_EN
  assign ce = pix_ce;
`else
  assign ce = 1'b1;
`endif

  assign h_in = (hc >= H_SS) && (hc < H_SE);
  assign v_in = (vc >= V_SS) && (vc < V_SE);

  // Outputs register the decode of the current counters, so they trail hc/vc by one clock.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      x           <= '0;
      y           <= '0;
      display_en  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        x           <= hc;
        y           <= vc;
        display_en  <= (hc < H_ACT) && (vc < V_ACT);
        h_sync      <= h_in ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync      <= v_in ? V_SYNC_POL : ~V_SYNC_POL;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
        if (hc == H_LST) begin
          hc <= '0;
          vc <= (vc == V_LST) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two small raster modes under random reset (and random pix_ce when enabled).
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs, vs, de, ls, fs;
    logic [9:0] x, y;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic [2:0] a_x, a_y;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [4:0] b_x;
  logic [3:0] b_y;

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .XW(3), .YW(3)) u_a (
    .clk_in(clk), .reset(reset),
`ifdef VGA_TIMING_PIX_CE_EN
    .pix_ce(ce),
`endif
    .h_sync(a_hs), .v_sync(a_vs), .display_en(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .XW(5), .YW(4)) u_b (
    .clk_in(clk), .reset(reset),
`ifdef VGA_TIMING_PIX_CE_EN
    .pix_ce(ce),
`endif
    .h_sync(b_hs), .v_sync(b_vs), .display_en(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs));

  int checks = 0;
  int errors = 0;
  out_t qa[$];
  out_t qb[$];

  // Reference: the counter is a linear pixel index within the frame.
  function automatic out_t decode(int ha, int hf, int hsn, int hb, int va, int vf, int vsn,
                                  bit hp, bit vp, int cnt);
    out_t d;
    int ht = ha + hf + hsn + hb;
    int xx = cnt % ht;
    int yy = cnt / ht;
    d.x  = 10'(xx);
    d.y  = 10'(yy);
    d.de = (xx < ha) && (yy < va);
    d.hs = (xx >= ha + hf && xx < ha + hf + hsn) ? hp : ~hp;
    d.vs = (yy >= va + vf && yy < va + vf + vsn) ? vp : ~vp;
    d.ls = (xx == 0);
    d.fs = (cnt == 0);
    return d;
  endfunction

  function automatic out_t rst_val(bit hp, bit vp);
    out_t d = '0;
    d.hs = ~hp;
    d.vs = ~vp;
    return d;
  endfunction

  task automatic cmp(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, want hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
               name, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y,
               exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each active edge.
  initial begin
    out_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() != 0) begin
        exp = qa.pop_front();
        act = '{hs: a_hs, vs: a_vs, de: a_de, ls: a_ls, fs: a_fs, x: 10'(a_x), y: 10'(a_y)};
        cmp("mode_a", act, exp);
      end
      if (qb.size() != 0) begin
        exp = qb.pop_front();
        act = '{hs: b_hs, vs: b_vs, de: b_de, ls: b_ls, fs: b_fs, x: 10'(b_x), y: 10'(b_y)};
        cmp("mode_b", act, exp);
      end
    end
  end

  // Stimulus plus model: every cycle picks reset/ce and queues the expected outputs.
  initial begin
    int   cnt_a = 0, cnt_b = 0;
    out_t pa = '0, pb = '0;
    out_t ea, eb;
    bit   r, c;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (n < 3)        r = 1'b1;
      else if (n < 700) r = 1'b0;
      else              r = ($urandom_range(0, 349) == 0);
`ifdef VGA_TIMING_PIX_CE_EN
      if (n < 1500) c = n[0];
      else          c = ($urandom_range(0, 2) != 0);
`else
      c = 1'b1;
`endif
      reset = r;
      ce    = c;
      if (r) begin
        ea = rst_val(1'b1, 1'b1);
        eb = rst_val(1'b0, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
      end else if (c) begin
        ea = decode(4, 1, 2, 1, 3, 1, 1, 1'b1, 1'b1, cnt_a);
        eb = decode(16, 2, 3, 2, 6, 2, 2, 1'b0, 1'b0, cnt_b);
        cnt_a = (cnt_a + 1) % (8 * 6);
        cnt_b = (cnt_b + 1) % (23 * 13);
      end else begin
        ea = pa;  ea.ls = 1'b0;  ea.fs = 1'b0;
        eb = pb;  eb.ls = 1'b0;  eb.fs = 1'b0;
      end
      pa = ea;
      pb = eb;
      qa.push_back(ea);
      qb.push_back(eb);
    end
    for (int w = 0; w < 10 && (qa.size() != 0 || qb.size() != 0); w++) @(posedge clk);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
